// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_bank clock-divider slice.
//   DIV_MIN      smallest divide ratio ever allowed to take effect
//   chan_state_e run/stop state of a channel (used when CLK_DIV_GATE_EN is defined)
//   ch_idx_w()   width of a channel index for a given channel count (at least 1)
//   clamp_div()  raises illegal ratios 0 and 1 to DIV_MIN
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } chan_state_e;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration/output bundle of clk_div_bank.
//   cfg_we/cfg_ch/cfg_div  ratio write strobe, target channel, requested ratio
//   sync                   one-cycle strobe restarting every channel at count 0
//   gate                   per-channel stop request (only when CLK_DIV_GATE_EN is defined)
//   ch_clk/ch_en/pending   divided clocks, end-of-period strobes, ratio-waiting flags
// master = configuring agent, slave = the divider bank.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DIV_W  = 8
) ();

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              sync;
`ifdef CLK_DIV_GATE_EN
  logic [NUM_CH-1:0] gate;
`endif
  logic [NUM_CH-1:0] ch_clk;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] pending;

  modport master (
    output cfg_we, cfg_ch, cfg_div, sync,
`ifdef CLK_DIV_GATE_EN
    output gate,
`endif
    input  ch_clk, ch_en, pending
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, sync,
`ifdef CLK_DIV_GATE_EN
    input  gate,
`endif
    output ch_clk, ch_en, pending
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/next ratio with pending flag,
// registered divided clock and end-of-period strobe.
//   clk, rst      board clock, async active-high reset
//   we, wdata     ratio write for this channel (clamped here)
//   sync          restart at count 0, apply any pending ratio now
//   gate          stop request, sampled at the period boundary (CLK_DIV_GATE_EN only)
//   ch_clk, ch_en divided clock and last-cycle-of-period strobe
//   pending       a written ratio waits for the next boundary
// Optional feature macro: CLK_DIV_GATE_EN.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      DIV_W = 8,
  parameter logic [DIV_W-1:0] DEF   = DIV_W'(2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DIV_W-1:0] wdata,
  input  logic             sync,
`ifdef CLK_DIV_GATE_EN
  input  logic             gate,
`endif
  output logic             ch_clk,
  output logic             ch_en,
  output logic             pending
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] nxt_q, nxt_d;
  logic             pend_d;
  logic             clk_d, en_d;
  logic             wrap;
  logic             stopped, gate_i, halt_d;

`ifdef CLK_DIV_GATE_EN
  chan_state_e state_q;
  assign stopped = (state_q == ST_STOP);
  assign gate_i  = gate;
`else
  assign stopped = 1'b0;
  assign gate_i  = 1'b0;
`endif

  // Next-state: boundary/sync restart, ratio hand-over, write capture, output decode
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    nxt_d  = nxt_q;
    pend_d = pending;
    halt_d = stopped;
    wrap   = (cnt_q == div_q - DIV_W'(1));

    if (stopped) begin
      cnt_d = '0;
      if (sync || !gate_i) begin
        if (pending) begin
          div_d  = nxt_q;
          pend_d = 1'b0;
        end
      end
      if (!gate_i) halt_d = 1'b0;
    end else if (sync || wrap) begin
      cnt_d = '0;
      if (pending) begin
        div_d  = nxt_q;
        pend_d = 1'b0;
      end
      if (wrap && gate_i) halt_d = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // A write on a boundary/sync edge lands after the hand-over, so it waits a full period
    if (we) begin
      nxt_d  = DIV_W'(clamp_div(32'(wdata)));
      pend_d = 1'b1;
    end

    clk_d = !halt_d && (cnt_d >= (div_d >> 1));
    en_d  = !halt_d && (cnt_d == div_d - DIV_W'(1));
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= DEF;
      nxt_q   <= '0;
      pending <= 1'b0;
      ch_clk  <= 1'b0;
      ch_en   <= 1'b0;
`ifdef CLK_DIV_GATE_EN
      state_q <= ST_RUN;
`endif
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      nxt_q   <= nxt_d;
      pending <= pend_d;
      ch_clk  <= clk_d;
      ch_en   <= en_d;
`ifdef CLK_DIV_GATE_EN
      state_q <= halt_d ? ST_STOP : ST_RUN;
`endif
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Programmable multi-channel clock divider. Decodes ratio writes to one
// channel and fans sync out to all of them.
//   B_CLK  board clock (sole clock)
//   RST    async active-high reset
//   bus    clk_div_bank_if.slave: cfg_we/cfg_ch/cfg_div/sync (+gate) in,
//          ch_clk/ch_en/pending out
// DEF_DIV packs the reset ratios, channel 0 in the least significant field.
// Optional feature macro: CLK_DIV_GATE_EN (per-channel stop via bus.gate).
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned             NUM_CH  = 3,
  parameter int unsigned             DIV_W   = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV = {8'd2, 8'd4, 8'd8}
) (
  input  logic           B_CLK,
  input  logic           RST,
  clk_div_bank_if.slave  bus
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] we;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Out-of-range indices match no channel, so such writes are dropped
    assign we[g] = bus.cfg_we && (bus.cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W (DIV_W),
      .DEF   (DEF_DIV[g*DIV_W +: DIV_W])
    ) u_chan (
      .clk     (B_CLK),
      .rst     (RST),
      .we      (we[g]),
      .wdata   (bus.cfg_div),
      .sync    (bus.sync),
`ifdef CLK_DIV_GATE_EN
      .gate    (bus.gate[g]),
`endif
      .ch_clk  (bus.ch_clk[g]),
      .ch_en   (bus.ch_en[g]),
      .pending (bus.pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: stimulus pushes per-edge expectations,
// a negedge monitor compares every output due at the current edge count.
module tb_clk_div_bank;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int          T0     = 2;   // absolute edge count at reset release

  logic B_CLK = 1'b0;
  logic RST   = 1'b1;
  int   ecnt  = 0;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .DEF_DIV ({8'd2, 8'd4, 8'd8})
  ) dut (
    .B_CLK (B_CLK),
    .RST   (RST),
    .bus   (bus)
  );

  always #5 B_CLK = ~B_CLK;
  always @(posedge B_CLK) ecnt <= ecnt + 1;

  typedef struct {
    int   e;
    int   sig;
    int   ch;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  task automatic push(input int e, input int sig, input int ch, input logic v);
    exp_t x;
    x.e = T0 + e; x.sig = sig; x.ch = ch; x.val = v;
    sb.push_back(x);
  endtask

  // Free-running channel of ratio d whose counter was 0 after edge org
  task automatic push_per(input int ch, input int d, input int org, input int from, input int to);
    int k;
    for (int e = from; e <= to; e++) begin
      k = (e - org) % d;
      push(e, 0, ch, k >= d / 2);
      push(e, 1, ch, k == d - 1);
    end
  endtask

  task automatic push_pend(input int ch, input int from, input int to, input logic v);
    for (int e = from; e <= to; e++) push(e, 2, ch, v);
  endtask

  task automatic push_zero(input int from, input int to);
    for (int e = from; e <= to; e++)
      for (int c = 0; c < 3; c++)
        for (int s = 0; s < 3; s++) push(e, s, c, 1'b0);
  endtask

  task automatic wait_edge(input int n);
    while (ecnt < T0 + n) begin
      @(posedge B_CLK);
      #1;
    end
  endtask

  task automatic write(input int ch, input int d);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 2'(ch);
    bus.cfg_div = 8'(d);
  endtask

  task automatic idle();
    bus.cfg_we = 1'b0;
  endtask

  function automatic logic sample(input int sig, input int ch);
    case (sig)
      0:       return bus.ch_clk[ch];
      1:       return bus.ch_en[ch];
      default: return bus.pending[ch];
    endcase
  endfunction

  function automatic string sname(input int sig);
    case (sig)
      0:       return "ch_clk";
      1:       return "ch_en";
      default: return "pending";
    endcase
  endfunction

  // Monitor: compare everything due at this edge, flush leftovers at the end
  always @(negedge B_CLK) begin
    logic got;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].e <= ecnt) begin
        got = sample(sb[i].sig, sb[i].ch);
        n_tests++;
        if (sb[i].e != ecnt || got !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s[%0d] edge %0d (seen at %0d): got %b expected %b",
                   sname(sb[i].sig), sb[i].ch, sb[i].e - T0, ecnt - T0, got, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      foreach (sb[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL unchecked %s[%0d] edge %0d: got none expected %b",
                 sname(sb[i].sig), sb[i].ch, sb[i].e - T0, sb[i].val);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_div = '0;
    bus.sync    = 1'b0;
`ifdef CLK_DIV_GATE_EN
    bus.gate    = '0;
`endif

    // Reset held, then default ratios 8/4/2 free-running from release
    push_zero(-1, 0);
    push_per(0, 8, 0, 1, 32);
    push_per(1, 4, 0, 1, 32);
    push_per(2, 2, 0, 1, 32);
    for (int c = 0; c < 3; c++) push_pend(c, 1, 32, 1'b0);
    wait_edge(0);
    RST = 1'b0;

    // Mid-period write ch0 D=5 at cnt=2: old period completes, new one at edge 40
    wait_edge(32);
    push_per(0, 8, 0, 33, 39);
    push_per(0, 5, 40, 40, 56);
    push_pend(0, 33, 34, 1'b0);
    push_pend(0, 35, 39, 1'b1);
    push_pend(0, 40, 56, 1'b0);
    push_per(1, 4, 0, 33, 56);
    push_per(2, 2, 0, 33, 56);
    push_pend(1, 33, 56, 1'b0);
    push_pend(2, 33, 56, 1'b0);
    wait_edge(34); write(0, 5);
    wait_edge(35); idle();

    // ch1: D=0 then D=6 (last wins), then D=1 clamps to 2; out-of-range index ignored
    wait_edge(56);
    push_per(1, 4, 0, 57, 59);
    push_per(1, 6, 60, 60, 65);
    push_per(1, 2, 66, 66, 80);
    push_pend(1, 57, 59, 1'b1);
    push_pend(1, 60, 60, 1'b0);
    push_pend(1, 61, 65, 1'b1);
    push_pend(1, 66, 80, 1'b0);
    push_per(0, 5, 40, 57, 80);
    push_per(2, 2, 0, 57, 80);
    push_pend(0, 57, 80, 1'b0);
    push_pend(2, 57, 80, 1'b0);
    write(1, 0);
    wait_edge(57); write(1, 6);
    wait_edge(58); idle();
    wait_edge(60); write(1, 1);
    wait_edge(61); idle();
    wait_edge(70); write(3, 7);
    wait_edge(71); idle();

    // Sync at edge 83 with ch0 pending D=3 and a simultaneous ch1 write D=4
    wait_edge(80);
    push_per(0, 5, 40, 81, 82);
    push_per(0, 3, 83, 83, 100);
    push_pend(0, 81, 82, 1'b1);
    push_pend(0, 83, 100, 1'b0);
    push_per(1, 2, 66, 81, 82);
    push_per(1, 2, 83, 83, 84);
    push_per(1, 4, 85, 85, 100);
    push_pend(1, 81, 82, 1'b0);
    push_pend(1, 83, 84, 1'b1);
    push_pend(1, 85, 100, 1'b0);
    push_per(2, 2, 0, 81, 82);
    push_per(2, 2, 83, 83, 100);
    push_pend(2, 81, 100, 1'b0);
    write(0, 3);
    wait_edge(81); idle();
    wait_edge(82); bus.sync = 1'b1; write(1, 4);
    wait_edge(83); bus.sync = 1'b0; idle();

    // Async reset between edges with ch2 pending: outputs clear, defaults resume
    wait_edge(100);
    push_zero(101, 103);
    push_per(0, 8, 103, 104, 130);
    push_per(1, 4, 103, 104, 130);
    push_per(2, 2, 103, 104, 130);
    for (int c = 0; c < 3; c++) push_pend(c, 104, 130, 1'b0);
    write(2, 7);
    wait_edge(101); idle();
    #2 RST = 1'b1;
    wait_edge(103);
    RST = 1'b0;
    last = 130;

`ifdef CLK_DIV_GATE_EN
    // Gate ch0 at cnt=3: finishes the period, stops at edge 135, restarts at edge 141
    wait_edge(130);
    push_per(0, 8, 103, 131, 134);
    for (int e = 135; e <= 140; e++) begin
      push(e, 0, 0, 1'b0);
      push(e, 1, 0, 1'b0);
    end
    push_per(0, 8, 141, 141, 160);
    push_per(1, 4, 103, 131, 160);
    push_per(2, 2, 103, 131, 160);
    for (int c = 0; c < 3; c++) push_pend(c, 131, 160, 1'b0);
    bus.gate = 3'b001;
    wait_edge(140);
    bus.gate = 3'b000;
    last = 160;
`endif

    wait_edge(last + 1);
    done = 1'b1;
  end

endmodule
